// File: rtl/lfsr_seq_checker_if.sv
// Stream and result bundle between the LFSR stage, its checker and the test harness.
interface lfsr_seq_checker_if #(
    parameter int NUM_BITS = 3,
    parameter int ERR_W    = 8
);
    logic                i_Enable;
    logic                i_Seed_DV;
    logic [NUM_BITS-1:0] i_LFSR_Data;
    logic                i_LFSR_Done;
    logic                i_Clear;
    logic [1:0]          o_State;
    logic                o_In_Sync;
    logic [ERR_W-1:0]    o_Err_Count;
    logic                o_Err_Flag;
    logic                o_Lockup;
    logic [NUM_BITS:0]   o_Period_Len;
    logic                o_Period_Valid;
    logic                o_Period_Ok;

    modport master (
        output i_Enable, i_Seed_DV, i_LFSR_Data, i_LFSR_Done, i_Clear,
        input  o_State, o_In_Sync, o_Err_Count, o_Err_Flag, o_Lockup,
               o_Period_Len, o_Period_Valid, o_Period_Ok
    );

    modport slave (
        input  i_Enable, i_Seed_DV, i_LFSR_Data, i_LFSR_Done, i_Clear,
        output o_State, o_In_Sync, o_Err_Count, o_Err_Flag, o_Lockup,
               o_Period_Len, o_Period_Valid, o_Period_Ok
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-check stage behind the XNOR LFSR: free-running reference, error count, lock-up and
// period measurement. Period logic is built only when LFSR_CHK_PERIOD_EN is defined.
module lfsr_seq_checker #(
    parameter int                  NUM_BITS = 3,
    parameter logic [NUM_BITS-1:0] TAPS     = 3'b110,
    parameter int                  ERR_W    = 8
) (
    input logic               i_Clk,
    input logic               i_Rst_L,
    lfsr_seq_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        LOCK  = 2'd3
    } state_t;

    state_t              r_State, w_State;
    logic [NUM_BITS-1:0] r_Exp, w_Exp;
    logic [ERR_W-1:0]    r_Err_Count, w_Err_Count;
    logic                r_Err_Flag, w_Err_Flag;
    logic                r_Lockup, w_Lockup;

`ifdef LFSR_CHK_PERIOD_EN
    localparam logic [NUM_BITS:0] PERIOD_FULL = {1'b0, {NUM_BITS{1'b1}}};
    logic [NUM_BITS:0] r_Cnt, w_Cnt, w_Cnt_Inc;
    logic [NUM_BITS:0] r_Period_Len, w_Period_Len;
    logic              r_Period_Valid, w_Period_Valid;
    logic              r_Period_Ok, w_Period_Ok;

    assign w_Cnt_Inc = r_Cnt + 1'b1;
`endif

    function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] d);
        return {d[NUM_BITS-2:0], ~^(d & TAPS)};
    endfunction

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State        <= IDLE;
            r_Exp          <= '0;
            r_Err_Count    <= '0;
            r_Err_Flag     <= 1'b0;
            r_Lockup       <= 1'b0;
`ifdef LFSR_CHK_PERIOD_EN
            r_Cnt          <= '0;
            r_Period_Len   <= '0;
            r_Period_Valid <= 1'b0;
            r_Period_Ok    <= 1'b0;
`endif
        end else begin
            r_State        <= w_State;
            r_Exp          <= w_Exp;
            r_Err_Count    <= w_Err_Count;
            r_Err_Flag     <= w_Err_Flag;
            r_Lockup       <= w_Lockup;
`ifdef LFSR_CHK_PERIOD_EN
            r_Cnt          <= w_Cnt;
            r_Period_Len   <= w_Period_Len;
            r_Period_Valid <= w_Period_Valid;
            r_Period_Ok    <= w_Period_Ok;
`endif
        end
    end

    always_comb begin
        w_State        = r_State;
        w_Exp          = r_Exp;
        w_Err_Count    = r_Err_Count;
        w_Err_Flag     = r_Err_Flag;
        w_Lockup       = r_Lockup;
`ifdef LFSR_CHK_PERIOD_EN
        w_Cnt          = r_Cnt;
        w_Period_Len   = r_Period_Len;
        w_Period_Valid = 1'b0;
        w_Period_Ok    = r_Period_Ok;
`endif
        if (bus.i_Seed_DV) begin
            w_State     = SYNC;
            w_Err_Count = '0;
            w_Err_Flag  = 1'b0;
            w_Lockup    = 1'b0;
`ifdef LFSR_CHK_PERIOD_EN
            w_Cnt       = '0;
`endif
        end else if (bus.i_Clear) begin
            // A clear cycle consumes the beat: the sample on this edge is not checked.
            w_Err_Count  = '0;
            w_Err_Flag   = 1'b0;
`ifdef LFSR_CHK_PERIOD_EN
            w_Period_Len = '0;
            w_Period_Ok  = 1'b0;
`endif
        end else if (bus.i_Enable) begin
            unique case (r_State)
                SYNC: begin
                    if (bus.i_LFSR_Data == '1) begin
                        w_State  = LOCK;
                        w_Lockup = 1'b1;
                    end else begin
                        w_Exp   = lfsr_next(bus.i_LFSR_Data);
                        w_State = CHECK;
`ifdef LFSR_CHK_PERIOD_EN
                        w_Cnt   = '0;
`endif
                    end
                end
                CHECK: begin
                    if (bus.i_LFSR_Data != r_Exp) begin
                        w_Err_Flag = 1'b1;
                        if (r_Err_Count != '1)
                            w_Err_Count = r_Err_Count + 1'b1;
                    end
                    w_Exp = lfsr_next(r_Exp);
`ifdef LFSR_CHK_PERIOD_EN
                    if (bus.i_LFSR_Done) begin
                        w_Period_Len   = w_Cnt_Inc;
                        w_Period_Valid = 1'b1;
                        w_Period_Ok    = (w_Cnt_Inc == PERIOD_FULL);
                        w_Cnt          = '0;
                    end else if (r_Cnt != '1) begin
                        w_Cnt = w_Cnt_Inc;
                    end
`endif
                    if (bus.i_LFSR_Data == '1) begin
                        w_State  = LOCK;
                        w_Lockup = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_State     = r_State;
    assign bus.o_In_Sync   = (r_State == CHECK);
    assign bus.o_Err_Count = r_Err_Count;
    assign bus.o_Err_Flag  = r_Err_Flag;
    assign bus.o_Lockup    = r_Lockup;
`ifdef LFSR_CHK_PERIOD_EN
    assign bus.o_Period_Len   = r_Period_Len;
    assign bus.o_Period_Valid = r_Period_Valid;
    assign bus.o_Period_Ok    = r_Period_Ok;
`else
    assign bus.o_Period_Len   = '0;
    assign bus.o_Period_Valid = 1'b0;
    assign bus.o_Period_Ok    = 1'b0;
`endif

endmodule
